// File: rtl/lift_pkg.sv
// -----------------------------------------------------------------------------
// lift_pkg
// Shared definitions for the lift scan controller: FSM state encoding,
// travel direction encoding and default parameter values.
// No ports (package).
// -----------------------------------------------------------------------------
package lift_pkg;

    localparam int DEF_N_FLOORS      = 8;
    localparam int DEF_TRAVEL_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES   = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic dir_t flip_dir(input dir_t d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

// File: rtl/lift_timer.sv
// -----------------------------------------------------------------------------
// lift_timer
// Loadable down-counter shared by travel and door timing. A load sets the
// count; otherwise the count decrements until it reaches zero. o_done is high
// during the final counted clock (count == 1), so the owner acts on the same
// edge that ends the interval.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   i_load      in   load i_load_val on this edge (wins over decrement)
//   i_load_val  in   number of clocks for the next interval
//   o_done      out  final clock of the current interval
// -----------------------------------------------------------------------------
module lift_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/lift_scan_ctrl.sv
// -----------------------------------------------------------------------------
// lift_scan_ctrl
// Single-cab scan (elevator algorithm) controller. Floor requests are latched
// into a pending vector; the cab keeps moving in its current direction while
// requests lie ahead, reverses when only requests behind remain, and opens the
// door at every pending floor it reaches.
//
// Ports:
//   clk            in   clock, all state on rising edge
//   rst_n          in   asynchronous active-low reset
//   req_valid      in   floor request strobe
//   req_floor      in   requested floor (out-of-range values are dropped)
//   current_floor  out  registered cab position
//   motor_up       out  high while moving up
//   motor_down     out  high while moving down
//   door_open      out  high while the door is open
//   pending        out  latched unserved requests, bit i = floor i
//   busy           out  cab not idle or requests outstanding
// -----------------------------------------------------------------------------
module lift_scan_ctrl
    import lift_pkg::*;
#(
    parameter  int N_FLOORS      = DEF_N_FLOORS,
    parameter  int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter  int DOOR_CYCLES   = DEF_DOOR_CYCLES,
    localparam int FLOOR_W       = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                busy
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES);
    localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] ONE_FLOOR   = FLOOR_W'(1);

    // One-hot floor decode; a floor index >= N_FLOORS decodes to all zeros,
    // which is how out-of-range requests get dropped.
    function automatic logic [N_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] v;
        v = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (int'(f) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic any_above(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]  f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(f)) r = r | p[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]  f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i < int'(f)) r = r | p[i];
        end
        return r;
    endfunction

    state_t              r_state;
    dir_t                r_dir;
    logic [FLOOR_W-1:0]  r_floor;
    logic [N_FLOORS-1:0] r_pending;

    state_t              w_next;
    dir_t                w_dir_nxt;
    logic [FLOOR_W-1:0]  w_floor_nxt;
    logic [FLOOR_W-1:0]  w_arr_floor;
    logic [FLOOR_W-1:0]  w_clr_floor;
    logic                w_clr;
    logic                w_load;
    logic [CNT_W-1:0]    w_load_val;
    logic                w_done;

    logic [N_FLOORS-1:0] w_req_oh;
    logic [N_FLOORS-1:0] w_set_mask;
    logic [N_FLOORS-1:0] w_clr_mask;
    logic                w_req_here;
    logic                w_here;
    logic                w_above_cur;
    logic                w_below_cur;
    logic                w_ahead_cur;
    logic                w_behind_cur;
    logic                w_arr_here;
    logic                w_arr_above;
    logic                w_arr_below;
    logic                w_arr_ahead;
    logic                w_arr_behind;

    lift_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Request decode. A request for the open-door floor only restarts the
    // door timer and is never latched.
    assign w_req_oh   = req_valid ? floor_onehot(req_floor) : '0;
    assign w_req_here = req_valid && (req_floor == r_floor);
    assign w_set_mask = ((r_state == ST_DOOR) && w_req_here) ? '0 : w_req_oh;
    assign w_clr_mask = w_clr ? floor_onehot(w_clr_floor) : '0;

    // Masks relative to the current floor (IDLE and DOOR decisions).
    assign w_here       = |(r_pending & floor_onehot(r_floor));
    assign w_above_cur  = any_above(r_pending, r_floor);
    assign w_below_cur  = any_below(r_pending, r_floor);
    assign w_ahead_cur  = (r_dir == DIR_UP) ? w_above_cur : w_below_cur;
    assign w_behind_cur = (r_dir == DIR_UP) ? w_below_cur : w_above_cur;

    // Floor reached at the end of the current travel interval, clamped to the
    // shaft so the position can never wrap.
    always_comb begin
        w_arr_floor = r_floor;
        if (r_state == ST_MOVE_DOWN) begin
            if (r_floor != '0) w_arr_floor = r_floor - ONE_FLOOR;
        end else if (r_state == ST_MOVE_UP) begin
            if (r_floor != TOP_FLOOR) w_arr_floor = r_floor + ONE_FLOOR;
        end
    end

    // Masks relative to the arrival floor (decisions on the arrival edge).
    assign w_arr_here   = |(r_pending & floor_onehot(w_arr_floor));
    assign w_arr_above  = any_above(r_pending, w_arr_floor);
    assign w_arr_below  = any_below(r_pending, w_arr_floor);
    assign w_arr_ahead  = (r_state == ST_MOVE_UP) ? w_arr_above : w_arr_below;
    assign w_arr_behind = (r_state == ST_MOVE_UP) ? w_arr_below : w_arr_above;

    always_comb begin
        w_next      = r_state;
        w_dir_nxt   = r_dir;
        w_floor_nxt = r_floor;
        w_load      = 1'b0;
        w_load_val  = TRAVEL_LOAD;
        w_clr       = 1'b0;
        w_clr_floor = r_floor;
        case (r_state)
            ST_IDLE: begin
                if (w_here) begin
                    w_next     = ST_DOOR;
                    w_load     = 1'b1;
                    w_load_val = DOOR_LOAD;
                    w_clr      = 1'b1;
                end else if (w_ahead_cur) begin
                    w_next = (r_dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                    w_load = 1'b1;
                end else if (w_behind_cur) begin
                    w_next    = (r_dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                    w_dir_nxt = flip_dir(r_dir);
                    w_load    = 1'b1;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (w_done) begin
                    w_floor_nxt = w_arr_floor;
                    if (w_arr_here) begin
                        w_next      = ST_DOOR;
                        w_load      = 1'b1;
                        w_load_val  = DOOR_LOAD;
                        w_clr       = 1'b1;
                        w_clr_floor = w_arr_floor;
                    end else if (w_arr_ahead) begin
                        w_load = 1'b1;
                    end else if (w_arr_behind) begin
                        w_next    = (r_state == ST_MOVE_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                        w_dir_nxt = flip_dir(r_dir);
                        w_load    = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                if (w_req_here) begin
                    // Restart wins even on the expiry clock: the door stays open.
                    w_load     = 1'b1;
                    w_load_val = DOOR_LOAD;
                end else if (w_done) begin
                    if (w_ahead_cur) begin
                        w_next = (r_dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                        w_load = 1'b1;
                    end else if (w_behind_cur) begin
                        w_next    = (r_dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                        w_dir_nxt = flip_dir(r_dir);
                        w_load    = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dir     <= DIR_UP;
            r_floor   <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_next;
            r_dir     <= w_dir_nxt;
            r_floor   <= w_floor_nxt;
            // Clear after set: a request arriving on its own service edge is
            // treated as already served.
            r_pending <= (r_pending | w_set_mask) & ~w_clr_mask;
        end
    end

    assign current_floor = r_floor;
    assign motor_up      = (r_state == ST_MOVE_UP);
    assign motor_down    = (r_state == ST_MOVE_DOWN);
    assign door_open     = (r_state == ST_DOOR);
    assign pending       = r_pending;
    assign busy          = (r_state != ST_IDLE) || (|r_pending);

endmodule

// File: tb/tb_lift_scan_ctrl.sv
module tb_lift_scan_ctrl;

    localparam int NF = 6;
    localparam int TC = 4;
    localparam int DC = 3;
    localparam int FW = $clog2(NF);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic [FW-1:0] current_floor;
    logic          motor_up;
    logic          motor_down;
    logic          door_open;
    logic [NF-1:0] pending;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int sb_q[$];
    logic prev_door = 1'b0;

    always #5 clk = ~clk;

    lift_scan_ctrl #(
        .N_FLOORS      (NF),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_floor     (req_floor),
        .current_floor (current_floor),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .door_open     (door_open),
        .pending       (pending),
        .busy          (busy)
    );

    // Scoreboard: every door opening pops the next expected stop floor.
    always @(negedge clk) begin : door_monitor
        int exp_f;
        if (!rst_n) begin
            prev_door = 1'b0;
        end else begin
            if (door_open && !prev_door) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL door_event: door opened at floor %0d, no stop expected", current_floor);
                end else begin
                    exp_f = sb_q.pop_front();
                    if (int'(current_floor) !== exp_f) begin
                        n_errors++;
                        $display("FAIL door_event: opened at floor %0d, expected floor %0d", current_floor, exp_f);
                    end
                end
            end
            prev_door = door_open;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (2) tick();
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_door_rise(input int max_cyc, output bit ok, output bit saw_up, output bit saw_down);
        bit was_closed;
        ok         = 1'b0;
        saw_up     = 1'b0;
        saw_down   = 1'b0;
        was_closed = !door_open;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (motor_up)   saw_up   = 1'b1;
            if (motor_down) saw_down = 1'b1;
            if (!door_open) was_closed = 1'b1;
            else if (was_closed) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_floor = 3'd3;
        repeat (3) tick();
        n_checks++;
        if (pending !== 6'b0) begin
            n_errors++; $display("FAIL reset_pending: got %b expected 000000", pending);
        end
        n_checks++;
        if (current_floor !== 3'd0) begin
            n_errors++; $display("FAIL reset_floor: got %0d expected 0", current_floor);
        end
        n_checks++;
        if ({motor_up, motor_down, door_open, busy} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_outputs: got %b expected 0000", {motor_up, motor_down, door_open, busy});
        end
        // First request after release is sampled on the first edge.
        rst_n     = 1'b1;
        req_floor = 3'd1;
        tick();
        req_valid = 1'b0;
        sb_q.push_back(1);
        n_checks++;
        if (pending !== 6'b000010) begin
            n_errors++; $display("FAIL reset_first_sample: pending %b expected 000010", pending);
        end
        wait_idle(60, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_errors++; $display("FAIL reset_serve_timeout: busy %b expected 0", busy);
        end
        n_checks++;
        if (current_floor !== 3'd1) begin
            n_errors++; $display("FAIL reset_serve_floor: got %0d expected 1", current_floor);
        end
    endtask

    task automatic test_basic_trip();
        logic          exp_up;
        logic          exp_door;
        logic [FW-1:0] exp_floor;
        apply_reset();
        req_valid = 1'b1;
        req_floor = 3'd2;
        tick();
        req_valid = 1'b0;
        sb_q.push_back(2);
        n_checks++;
        if (pending !== 6'b000100 || motor_up !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_sampled: pending %b up %b busy %b expected 000100 0 1", pending, motor_up, busy);
        end
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp_up    = (j <= 8);
            exp_door  = (j >= 9 && j <= 11);
            exp_floor = (j < 5) ? 3'd0 : ((j < 9) ? 3'd1 : 3'd2);
            n_checks++;
            if (motor_up !== exp_up) begin
                n_errors++; $display("FAIL basic_motor_up k+%0d: got %b expected %b", j, motor_up, exp_up);
            end
            n_checks++;
            if (door_open !== exp_door) begin
                n_errors++; $display("FAIL basic_door k+%0d: got %b expected %b", j, door_open, exp_door);
            end
            n_checks++;
            if (current_floor !== exp_floor) begin
                n_errors++; $display("FAIL basic_floor k+%0d: got %0d expected %0d", j, current_floor, exp_floor);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || pending !== 6'b0) begin
            n_errors++; $display("FAIL basic_idle: busy %b pending %b expected 0 000000", busy, pending);
        end
    endtask

    task automatic test_scan_reverse();
        int            stops[3];
        logic [NF-1:0] exp_pend[3];
        bit            ok;
        bit            saw_up;
        bit            saw_down;
        bit            ok_idle;
        stops    = '{3, 5, 1};
        exp_pend = '{6'b100010, 6'b000010, 6'b000000};
        apply_reset();
        req_valid = 1'b1; req_floor = 3'd5;
        tick();
        req_valid = 1'b0;
        tick();
        req_valid = 1'b1; req_floor = 3'd3;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (current_floor !== 3'd1 || motor_up !== 1'b1) begin
            n_errors++; $display("FAIL scan_passing_1: floor %0d up %b expected 1 1", current_floor, motor_up);
        end
        req_valid = 1'b1; req_floor = 3'd1;
        tick();
        req_valid = 1'b0;
        sb_q.push_back(3); sb_q.push_back(5); sb_q.push_back(1);
        n_checks++;
        if (pending !== 6'b101010) begin
            n_errors++; $display("FAIL scan_pending: got %b expected 101010", pending);
        end
        for (int s = 0; s < 3; s++) begin
            wait_door_rise(100, ok, saw_up, saw_down);
            n_checks++;
            if (ok !== 1'b1) begin
                n_errors++; $display("FAIL scan_stop_timeout: stop %0d never reached", stops[s]);
            end
            n_checks++;
            if (int'(current_floor) !== stops[s]) begin
                n_errors++; $display("FAIL scan_stop_floor: got %0d expected %0d", current_floor, stops[s]);
            end
            n_checks++;
            if (pending !== exp_pend[s]) begin
                n_errors++; $display("FAIL scan_stop_pending at %0d: got %b expected %b", stops[s], pending, exp_pend[s]);
            end
            if (s < 2) begin
                n_checks++;
                if (saw_down !== 1'b0) begin
                    n_errors++; $display("FAIL scan_no_down before %0d: saw_down %b expected 0", stops[s], saw_down);
                end
            end else begin
                n_checks++;
                if (saw_up !== 1'b0 || saw_down !== 1'b1) begin
                    n_errors++; $display("FAIL scan_reverse: saw_up %b saw_down %b expected 0 1", saw_up, saw_down);
                end
            end
        end
        wait_idle(20, ok_idle);
        n_checks++;
        if (ok_idle !== 1'b1 || current_floor !== 3'd1) begin
            n_errors++; $display("FAIL scan_final: idle %b floor %0d expected 1 1", ok_idle, current_floor);
        end
    endtask

    task automatic test_door_extend();
        logic exp_door;
        apply_reset();
        req_valid = 1'b1; req_floor = 3'd0;
        tick();
        req_valid = 1'b0;
        sb_q.push_back(0);
        n_checks++;
        if (door_open !== 1'b0 || pending !== 6'b000001) begin
            n_errors++; $display("FAIL door_sampled: door %b pending %b expected 0 000001", door_open, pending);
        end
        tick();
        n_checks++;
        if (door_open !== 1'b1 || pending !== 6'b0) begin
            n_errors++; $display("FAIL door_open_next: door %b pending %b expected 1 000000", door_open, pending);
        end
        req_valid = 1'b1; req_floor = 3'd0;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (door_open !== 1'b1 || pending !== 6'b0) begin
            n_errors++; $display("FAIL door_restart_nolatch: door %b pending %b expected 1 000000", door_open, pending);
        end
        for (int j = 3; j <= 6; j++) begin
            tick();
            exp_door = (j <= 4);
            n_checks++;
            if (door_open !== exp_door) begin
                n_errors++; $display("FAIL door_extend k+%0d: got %b expected %b", j, door_open, exp_door);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL door_extend_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_out_of_range();
        logic [FW-1:0] bad[2];
        bad = '{3'd6, 3'd7};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_floor = bad[i];
            tick();
            req_valid = 1'b0;
            n_checks++;
            if (pending !== 6'b0 || busy !== 1'b0) begin
                n_errors++; $display("FAIL oor_pending floor %0d: pending %b busy %b expected 000000 0", bad[i], pending, busy);
            end
            tick();
            n_checks++;
            if ({motor_up, motor_down, door_open} !== 3'b000) begin
                n_errors++; $display("FAIL oor_state floor %0d: got %b expected 000", bad[i], {motor_up, motor_down, door_open});
            end
        end
    endtask

    task automatic test_reset_mid_travel();
        apply_reset();
        req_valid = 1'b1; req_floor = 3'd4;
        tick();
        req_valid = 1'b0;
        sb_q.push_back(4);
        repeat (10) tick();
        n_checks++;
        if (current_floor !== 3'd2 || motor_up !== 1'b1 || pending !== 6'b010000) begin
            n_errors++; $display("FAIL midrst_before: floor %0d up %b pending %b expected 2 1 010000", current_floor, motor_up, pending);
        end
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        n_checks++;
        if (current_floor !== 3'd0 || pending !== 6'b0) begin
            n_errors++; $display("FAIL midrst_async: floor %0d pending %b expected 0 000000", current_floor, pending);
        end
        n_checks++;
        if ({motor_up, motor_down, door_open, busy} !== 4'b0000) begin
            n_errors++; $display("FAIL midrst_outputs: got %b expected 0000", {motor_up, motor_down, door_open, busy});
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0 || current_floor !== 3'd0) begin
            n_errors++; $display("FAIL midrst_after: busy %b floor %0d expected 0 0", busy, current_floor);
        end
    endtask

    task automatic test_arrival_collision();
        logic exp_door;
        apply_reset();
        req_valid = 1'b1; req_floor = 3'd4;
        tick();
        req_valid = 1'b0;
        sb_q.push_back(4);
        repeat (16) tick();
        n_checks++;
        if (current_floor !== 3'd3 || motor_up !== 1'b1) begin
            n_errors++; $display("FAIL collide_approach: floor %0d up %b expected 3 1", current_floor, motor_up);
        end
        req_valid = 1'b1; req_floor = 3'd4;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (door_open !== 1'b1 || current_floor !== 3'd4 || pending !== 6'b0) begin
            n_errors++; $display("FAIL collide_arrive: door %b floor %0d pending %b expected 1 4 000000", door_open, current_floor, pending);
        end
        for (int j = 18; j <= 22; j++) begin
            tick();
            exp_door = (j <= 19);
            n_checks++;
            if (door_open !== exp_door || pending !== 6'b0) begin
                n_errors++; $display("FAIL collide_door k+%0d: door %b pending %b expected %b 000000", j, door_open, pending, exp_door);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL collide_idle: busy %b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_trip();
        test_scan_reverse();
        test_door_extend();
        test_out_of_range();
        test_reset_mid_travel();
        test_arrival_collision();
        repeat (2) tick();
        n_checks++;
        if (sb_q.size() !== 0) begin
            n_errors++; $display("FAIL scoreboard_drain: %0d stops outstanding, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
